// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational 4-bit ALU.
// Optional per-requester/overflow response counters are enabled with ALU_ARBITER_STATS_EN.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req0_c,
  input  logic       req1_c,
  input  logic [3:0] req0_mode,
  input  logic [3:0] req1_mode,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       C,
  output logic [3:0] Mode,
  input  logic [3:0] R,
  input  logic       overFlow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic       rsp_ovf
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1,
  output logic [7:0] ovf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] LAST_CNT = 3'(EXEC_CYCLES - 1);

  state_t     r_state;
  logic       r_last;
  logic [2:0] r_cnt;

  logic w_any, w_gnt, w_grant, w_hs;

  assign w_any   = req0_valid | req1_valid;
  // tie goes to whoever was not served last; a lone requester always wins
  assign w_gnt   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_grant = (r_state == IDLE) & w_any & ~rst;
  assign w_hs    = (r_state == RESP) & rsp_ready;

  assign req0_ready = w_grant & ~w_gnt;
  assign req1_ready = w_grant &  w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 3'd0;
      A         <= 4'd0;
      B         <= 4'd0;
      C         <= 1'b0;
      Mode      <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= 4'd0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          A       <= w_gnt ? req1_a    : req0_a;
          B       <= w_gnt ? req1_b    : req0_b;
          C       <= w_gnt ? req1_c    : req0_c;
          Mode    <= w_gnt ? req1_mode : req0_mode;
          rsp_id  <= w_gnt;
          r_cnt   <= 3'd0;
          r_state <= EXEC;
        end
        EXEC: if (r_cnt == LAST_CNT) begin
          rsp_r     <= R;
          rsp_ovf   <= overFlow;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_last    <= rsp_id;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0    <= 8'd0;
      cnt1    <= 8'd0;
      ovf_cnt <= 8'd0;
    end else if (w_hs) begin
      if (rsp_id) cnt1 <= cnt1 + 8'd1;
      else        cnt0 <= cnt0 + 8'd1;
      if (rsp_ovf) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_hs;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=4,
// each wired to an adder stub ALU (R = A+B+C mod 16, overFlow = carry-out).
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v0, v1, c0, c1, rdy0, rdy1, cc, r_ready, rv, rid, rovf, ovf;
  logic [3:0] a0, b0, a1, b1, m0, m1, aa, bb, mm, rr, rsp;
  logic       q0v, q1v, q1c, qr0, qr1, qcc, qrv, qrid, qrovf, qovf;
  logic [3:0] q1a, q1b, qaa, qbb, qmm, qrr, qrsp;
  logic [3:0] zero4;
  logic       zero1, one1;
`ifdef ALU_ARBITER_STATS_EN
  logic [7:0] s_cnt0, s_cnt1, s_ovf, t_cnt0, t_cnt1, t_ovf;
`endif

  assign {ovf, rr}   = {1'b0, aa} + {1'b0, bb} + {4'd0, cc};
  assign {qovf, qrr} = {1'b0, qaa} + {1'b0, qbb} + {4'd0, qcc};
  assign zero4 = 4'd0;
  assign zero1 = 1'b0;
  assign one1  = 1'b1;

  alu_arbiter #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .req0_c(c0), .req1_c(c1), .req0_mode(m0), .req1_mode(m1),
    .req0_ready(rdy0), .req1_ready(rdy1),
    .A(aa), .B(bb), .C(cc), .Mode(mm), .R(rr), .overFlow(ovf),
    .rsp_valid(rv), .rsp_ready(r_ready), .rsp_id(rid), .rsp_r(rsp), .rsp_ovf(rovf)
`ifdef ALU_ARBITER_STATS_EN
    , .cnt0(s_cnt0), .cnt1(s_cnt1), .ovf_cnt(s_ovf)
`endif
  );

  alu_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(q0v), .req1_valid(q1v),
    .req0_a(zero4), .req0_b(zero4), .req1_a(q1a), .req1_b(q1b),
    .req0_c(zero1), .req1_c(q1c), .req0_mode(zero4), .req1_mode(zero4),
    .req0_ready(qr0), .req1_ready(qr1),
    .A(qaa), .B(qbb), .C(qcc), .Mode(qmm), .R(qrr), .overFlow(qovf),
    .rsp_valid(qrv), .rsp_ready(one1), .rsp_id(qrid), .rsp_r(qrsp), .rsp_ovf(qrovf)
`ifdef ALU_ARBITER_STATS_EN
    , .cnt0(t_cnt0), .cnt1(t_cnt1), .ovf_cnt(t_ovf)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; r_ready = 1'b1;
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; c0 = 0; m0 = 0; a1 = 0; b1 = 0; c1 = 0; m1 = 0;
    q0v = 0; q1v = 0; q1a = 0; q1b = 0; q1c = 0;
    cyc;
    chk("rst_A", aa, 0); chk("rst_B", bb, 0); chk("rst_C", cc, 0); chk("rst_Mode", mm, 0);
    chk("rst_rv", rv, 0); chk("rst_id", rid, 0); chk("rst_r", rsp, 0); chk("rst_ovf", rovf, 0);

    // single req0: 5+10+1 = 16 -> r=0, carry 1
    rst = 0; v0 = 1; a0 = 4'b0101; b0 = 4'b1010; c0 = 1; m0 = 4'b0000;
    #1; chk("t1_rdy0", rdy0, 1); chk("t1_rdy1", rdy1, 0);
    cyc; chk("t1_exec_rdy0", rdy0, 0); chk("t1_exec_rv", rv, 0);
    chk("t1_A", aa, 4'b0101); chk("t1_B", bb, 4'b1010); chk("t1_C", cc, 1);
    a0 = 4'hF; v0 = 0;
    cyc; chk("t1_rv", rv, 1); chk("t1_id", rid, 0); chk("t1_r", rsp, 0); chk("t1_ovf", rovf, 1);
    chk("t1_A_hold", aa, 4'b0101);
    cyc; chk("t1_idle_rv", rv, 0);

    // both valid from reset: grants alternate 0,1,0,1
    rst = 1; v0 = 1; v1 = 1;
    a0 = 4'd1; b0 = 4'd2; c0 = 0; a1 = 4'b0011; b1 = 4'b0101; c1 = 0;
    cyc; chk("t2_rst_rdy0", rdy0, 0);
    rst = 0; #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t2_rdy0_%0d", g), rdy0, (g % 2) == 0);
      chk($sformatf("t2_rdy1_%0d", g), rdy1, (g % 2) == 1);
      cyc; chk($sformatf("t2_exec_rv_%0d", g), rv, 0);
      cyc; chk($sformatf("t2_rv_%0d", g), rv, 1);
      chk($sformatf("t2_id_%0d", g), rid, g % 2);
      chk($sformatf("t2_r_%0d", g), rsp, (g % 2) ? 4'b1000 : 4'b0011);
      chk($sformatf("t2_ovf_%0d", g), rovf, 0);
      cyc;
      if (g == 3) begin v0 = 0; v1 = 0; end
    end

    // response back-pressure: payload held, nothing granted until handshake
    r_ready = 0; v0 = 1; a0 = 4'd2; b0 = 4'd3; c0 = 1; m0 = 4'h9;
    #1; chk("t3_rdy0", rdy0, 1);
    cyc; v0 = 0; v1 = 1; a1 = 4'hA; b1 = 4'hA;
    cyc;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_rv_%0d", k), rv, 1); chk($sformatf("t3_r_%0d", k), rsp, 4'd6);
      chk($sformatf("t3_id_%0d", k), rid, 0); chk($sformatf("t3_ovf_%0d", k), rovf, 0);
      chk($sformatf("t3_rdy0_%0d", k), rdy0, 0); chk($sformatf("t3_rdy1_%0d", k), rdy1, 0);
      chk($sformatf("t3_A_%0d", k), aa, 4'd2); chk($sformatf("t3_Mode_%0d", k), mm, 4'h9);
      cyc;
    end
    r_ready = 1; a1 = 4'hF; b1 = 4'h1; c1 = 0;
    cyc; chk("t3_post_rv", rv, 0); chk("t3_post_rdy1", rdy1, 1);
    cyc; v1 = 0; chk("t3_q1_A", aa, 4'hF);
    cyc; chk("t3_q1_rv", rv, 1); chk("t3_q1_id", rid, 1); chk("t3_q1_r", rsp, 0); chk("t3_q1_ovf", rovf, 1);
    cyc;

    // reset while executing discards the operation
    v0 = 1; a0 = 4'd4; b0 = 4'd4; c0 = 0;
    #1; chk("t4_rdy0", rdy0, 1);
    cyc; v0 = 0; rst = 1;
    #1; chk("t4_A", aa, 0); chk("t4_B", bb, 0); chk("t4_rv", rv, 0);
    cyc; rst = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_norsp_%0d", k), rv, 0);
      cyc;
    end
    v0 = 1; a0 = 4'd9; b0 = 4'd9; c0 = 1;
    #1; chk("t4b_rdy0", rdy0, 1);
    cyc; v0 = 0;
    cyc; chk("t4b_rv", rv, 1); chk("t4b_r", rsp, 4'd3); chk("t4b_ovf", rovf, 1); chk("t4b_id", rid, 0);
    cyc;
`ifdef ALU_ARBITER_STATS_EN
    chk("t4b_cnt0", s_cnt0, 1); chk("t4b_cnt1", s_cnt1, 0); chk("t4b_ovfcnt", s_ovf, 1);
`endif

    // EXEC_CYCLES=4: 12+12 = 24 -> r=8, carry 1
    q1v = 1; q1a = 4'b1100; q1b = 4'b1100; q1c = 0;
    #1; chk("t5_rdy1", qr1, 1); chk("t5_rdy0", qr0, 0);
    cyc; q1v = 0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t5_exec_rv_%0d", k), qrv, 0);
      chk($sformatf("t5_exec_A_%0d", k), qaa, 4'b1100);
      cyc;
    end
    chk("t5_rv", qrv, 1); chk("t5_r", qrsp, 4'b1000); chk("t5_ovf", qrovf, 1); chk("t5_id", qrid, 1);
    cyc; chk("t5_idle_rv", qrv, 0);
`ifdef ALU_ARBITER_STATS_EN
    chk("t5_cnt1", t_cnt1, 1); chk("t5_ovfcnt", t_ovf, 1); chk("t5_cnt0", t_cnt0, 0);
    for (int n = 0; n < 255; n++) begin
      q1v = 1;
      cyc; q1v = 0;
      repeat (5) cyc;
    end
    chk("t5_cnt1_wrap", t_cnt1, 0); chk("t5_ovfcnt_wrap", t_ovf, 0); chk("t5_cnt0_wrap", t_cnt0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
